// File: rtl/cobs_frame_fifo.sv
// Store-and-forward buffer for a COBS byte stream (frames end in 0x00).
// Bytes are written speculatively; a frame becomes readable only once its
// delimiter lands, and a frame that runs out of room is dropped whole.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_PASS | accepting bytes into the buffer (or rewinding on overflow)
// ST_DROP | discarding the rest of an overflowed frame up to its 0x00
module cobs_frame_fifo #(
    parameter int DEPTH       = 64,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [7:0]             in_tdata,
    input  logic                   in_tvalid,
    output logic                   in_tready,
    output logic [7:0]             out_tdata,
    output logic                   out_tvalid,
    input  logic                   out_tready,
    output logic                   out_tlast,
    output logic [COUNT_WIDTH-1:0] frames_pending,
    output logic [COUNT_WIDTH-1:0] frames_dropped
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic {
        ST_PASS = 1'b0,
        ST_DROP = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]          commit_ptr_q, commit_ptr_d;
    logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
    logic                   in_tready_q;
    logic [COUNT_WIDTH-1:0] frames_pending_q, frames_pending_d;
    logic [COUNT_WIDTH-1:0] frames_dropped_q, frames_dropped_d;
    logic [7:0]             mem_q [DEPTH];

    logic accept;
    logic full;
    logic is_delim;
    logic mem_we;
    logic commit;
    logic drop;
    logic rd_fire;

    assign accept   = in_tvalid && in_tready_q;
    // Occupancy counts speculative bytes too; a same-cycle read frees nothing.
    assign full     = (wr_ptr_q - rd_ptr_q) == PW'(DEPTH);
    assign is_delim = (in_tdata == 8'h00);

    assign in_tready  = in_tready_q;
    assign out_tvalid = (rd_ptr_q != commit_ptr_q);
    assign out_tdata  = mem_q[rd_ptr_q[AW-1:0]];
    assign out_tlast  = out_tvalid && (out_tdata == 8'h00);
    assign rd_fire    = out_tvalid && out_tready;

    assign frames_pending = frames_pending_q;
    assign frames_dropped = frames_dropped_q;

    // Write-side FSM: speculative write, commit on delimiter, rewind on overflow.
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        mem_we       = 1'b0;
        commit       = 1'b0;
        drop         = 1'b0;
        case (state_q)
            ST_PASS: begin
                if (accept) begin
                    if (!full) begin
                        mem_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + PW'(1);
                        if (is_delim) begin
                            commit_ptr_d = wr_ptr_q + PW'(1);
                            commit       = 1'b1;
                        end
                    end else begin
                        wr_ptr_d = commit_ptr_q;
                        drop     = 1'b1;
                        if (!is_delim) begin
                            state_d = ST_DROP;
                        end
                    end
                end
            end
            ST_DROP: begin
                if (accept && is_delim) begin
                    state_d = ST_PASS;
                end
            end
            default: state_d = ST_PASS;
        endcase
    end

    // Read pointer and status counters.
    always_comb begin
        rd_ptr_d         = rd_ptr_q + (rd_fire ? PW'(1) : PW'(0));
        frames_pending_d = frames_pending_q;
        frames_dropped_d = frames_dropped_q;
        case ({commit, rd_fire && out_tlast})
            2'b10:   frames_pending_d = frames_pending_q + COUNT_WIDTH'(1);
            2'b01:   frames_pending_d = frames_pending_q - COUNT_WIDTH'(1);
            default: frames_pending_d = frames_pending_q;
        endcase
        if (drop && !(&frames_dropped_q)) begin
            frames_dropped_d = frames_dropped_q + COUNT_WIDTH'(1);
        end
    end

    // Control registers; an in-flight frame simply vanishes on reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= ST_PASS;
            wr_ptr_q         <= '0;
            commit_ptr_q     <= '0;
            rd_ptr_q         <= '0;
            in_tready_q      <= 1'b0;
            frames_pending_q <= '0;
            frames_dropped_q <= '0;
        end else begin
            state_q          <= state_d;
            wr_ptr_q         <= wr_ptr_d;
            commit_ptr_q     <= commit_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            in_tready_q      <= 1'b1;
            frames_pending_q <= frames_pending_d;
            frames_dropped_q <= frames_dropped_d;
        end
    end

    // Byte storage, deliberately not reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wr_ptr_q[AW-1:0]] <= in_tdata;
        end
    end

endmodule

// File: tb/tb_cobs_frame_fifo.sv
module tb_cobs_frame_fifo;

    localparam int DEPTH = 8;
    localparam int CW    = 16;
    localparam int MAXC  = 65535;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [7:0]    in_tdata = 8'h00;
    logic          in_tvalid = 1'b0;
    logic          in_tready;
    logic [7:0]    out_tdata;
    logic          out_tvalid;
    logic          out_tready = 1'b0;
    logic          out_tlast;
    logic [CW-1:0] frames_pending;
    logic [CW-1:0] frames_dropped;

    cobs_frame_fifo #(.DEPTH(DEPTH), .COUNT_WIDTH(CW)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .in_tdata       (in_tdata),
        .in_tvalid      (in_tvalid),
        .in_tready      (in_tready),
        .out_tdata      (out_tdata),
        .out_tvalid     (out_tvalid),
        .out_tready     (out_tready),
        .out_tlast      (out_tlast),
        .frames_pending (frames_pending),
        .frames_dropped (frames_dropped)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: committed bytes, the frame being assembled, a drop flag.
    logic [7:0] cq[$];
    logic [7:0] pq[$];
    logic [7:0] got[$];
    bit         m_dropping = 0;
    bit         m_ready = 0;
    int         m_dropped = 0;

    function automatic int zeros_committed();
        int n = 0;
        foreach (cq[i]) if (cq[i] == 8'h00) n++;
        return n;
    endfunction

    // Compare DUT against the model, then advance the model by one clock edge.
    always @(negedge clk) begin
        if (!reset_n) begin
            chk("rst_in_tready", in_tready, 0);
            chk("rst_out_tvalid", out_tvalid, 0);
            chk("rst_out_tlast", out_tlast, 0);
            chk("rst_frames_pending", frames_pending, 0);
            chk("rst_frames_dropped", frames_dropped, 0);
            cq.delete(); pq.delete();
            m_dropping = 0; m_ready = 0; m_dropped = 0;
        end else begin
            bit acc, fire, full;
            chk("in_tready", in_tready, m_ready);
            chk("out_tvalid", out_tvalid, cq.size() != 0);
            if (cq.size() != 0) begin
                chk("out_tdata", out_tdata, cq[0]);
                chk("out_tlast", out_tlast, cq[0] == 8'h00);
            end else begin
                chk("out_tlast_idle", out_tlast, 0);
            end
            chk("frames_pending", frames_pending, zeros_committed());
            chk("frames_dropped", frames_dropped, m_dropped);

            acc  = in_tvalid && m_ready;
            fire = out_tready && (cq.size() != 0);
            full = (cq.size() + pq.size()) == DEPTH;
            if (fire) got.push_back(cq.pop_front());
            if (acc) begin
                if (m_dropping) begin
                    if (in_tdata == 8'h00) m_dropping = 0;
                end else if (full) begin
                    pq.delete();
                    if (m_dropped != MAXC) m_dropped++;
                    if (in_tdata != 8'h00) m_dropping = 1;
                end else begin
                    pq.push_back(in_tdata);
                    if (in_tdata == 8'h00) begin
                        foreach (pq[i]) cq.push_back(pq[i]);
                        pq.delete();
                    end
                end
            end
            m_ready = 1;
        end
    end

    // out_tready source: 0 = hold low, 1 = hold high, 2 = random.
    int ready_mode = 0;
    always @(posedge clk) begin
        #1;
        if (ready_mode == 2) out_tready = 1'($urandom_range(0, 1));
        else out_tready = (ready_mode == 1);
    end

    task automatic set_mode(input int m);
        ready_mode = m;
        if (m != 2) out_tready = (m == 1);
    endtask

    task automatic send_byte(input logic [7:0] b);
        in_tvalid = 1'b1;
        in_tdata  = b;
        @(posedge clk); #1;
        in_tvalid = 1'b0;
        in_tdata  = 8'($urandom);
    endtask

    task automatic send_frame(input logic [7:0] f[$]);
        foreach (f[i]) send_byte(f[i]);
    endtask

    task automatic wait_drain(input int max_cycles);
        int n = 0;
        while (cq.size() != 0 && n < max_cycles) begin
            @(posedge clk); #1;
            n++;
        end
        if (cq.size() != 0) chk("drain_timeout", cq.size(), 0);
    endtask

    task automatic check_got(input string name, input logic [7:0] exp[$]);
        chk({name, "_len"}, got.size(), exp.size());
        foreach (exp[i]) begin
            if (i < got.size()) chk(name, got[i], exp[i]);
        end
        got.delete();
    endtask

    initial begin
        logic [7:0] fa[$];
        logic [7:0] exp[$];
        fa = '{8'h01, 8'h02, 8'h0F, 8'h02, 8'h07, 8'h00};

        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        chk("in_tready_after_release", in_tready, 0);
        @(posedge clk); #1;
        chk("in_tready_one_edge_later", in_tready, 1);
        got.delete();

        // Single frame with a free-running sink.
        set_mode(1);
        send_frame(fa);
        chk("t1_pending_after_delim", frames_pending, 1);
        wait_drain(50);
        check_got("t1_bytes", fa);

        // Back-pressure: three small frames held, then random drain.
        set_mode(0);
        send_frame('{8'h01, 8'h00});
        send_frame('{8'h02, 8'hAA, 8'h00});
        send_frame('{8'h01, 8'h00});
        chk("t2_pending_held", frames_pending, 3);
        set_mode(2);
        wait_drain(500);
        check_got("t2_bytes", '{8'h01, 8'h00, 8'h02, 8'hAA, 8'h00, 8'h01, 8'h00});
        chk("t2_pending_drained", frames_pending, 0);

        // Overflow: A fits, B overflows on its 3rd byte.
        set_mode(0);
        send_frame(fa);
        send_frame(fa);
        chk("t3_dropped", frames_dropped, 1);
        chk("t3_pending", frames_pending, 1);
        set_mode(1);
        wait_drain(50);
        check_got("t3_bytes", fa);

        // Recovery after the drop.
        send_frame(fa);
        wait_drain(50);
        check_got("t4_bytes", fa);
        chk("t4_dropped", frames_dropped, 1);

        // Wrap-around with short frames.
        exp.delete();
        for (int i = 0; i < 20; i++) begin
            send_frame('{8'h02, 8'hAA, 8'h00});
            exp.push_back(8'h02); exp.push_back(8'hAA); exp.push_back(8'h00);
        end
        wait_drain(50);
        check_got("t5_bytes", exp);
        chk("t5_dropped", frames_dropped, 1);

        // Randomized traffic, including oversized frames and idle gaps.
        set_mode(2);
        for (int f = 0; f < 200; f++) begin
            int len = $urandom_range(0, 10);
            for (int i = 0; i < len; i++) begin
                send_byte(8'($urandom_range(1, 255)));
                if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
            end
            send_byte(8'h00);
            if ($urandom_range(0, 2) == 0) set_mode($urandom_range(0, 2));
        end
        set_mode(1);
        wait_drain(100);
        got.delete();

        // Reset mid-frame with a frame still pending.
        set_mode(0);
        send_frame('{8'h01, 8'h00});
        chk("t6_pending_before", frames_pending, 1);
        send_byte(8'h03); send_byte(8'h11); send_byte(8'h22);
        reset_n = 1'b0;
        #1;
        chk("t6_in_tready", in_tready, 0);
        chk("t6_out_tvalid", out_tvalid, 0);
        chk("t6_out_tlast", out_tlast, 0);
        chk("t6_pending", frames_pending, 0);
        chk("t6_dropped", frames_dropped, 0);
        @(posedge clk); @(posedge clk); #1;
        reset_n = 1'b1;
        chk("t6_ready_at_release", in_tready, 0);
        @(posedge clk); #1;
        chk("t6_ready_after_edge", in_tready, 1);
        got.delete();
        set_mode(1);
        send_frame('{8'h03, 8'h11, 8'h22, 8'h00});
        wait_drain(50);
        check_got("t6_bytes", '{8'h03, 8'h11, 8'h22, 8'h00});
        chk("t6_pending_end", frames_pending, 0);
        chk("t6_dropped_end", frames_dropped, 0);

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
